// File: rtl/div_sign_ctrl.sv
// Sign/special-case controller wrapped around the unsigned iterative divider core.
// Resolves RISC-V DIV/DIVU/REM/REMU divide-by-zero and signed overflow locally,
// feeds operand magnitudes to the core, and sign-corrects the core's answer.
module div_sign_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clk_en_i,
    input  logic [DATA_W-1:0] rs1_i,
    input  logic [DATA_W-1:0] rs2_i,
    input  logic [1:0]        op_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] core_dividend_o,
    output logic [DATA_W-1:0] core_divisor_o,
    output logic              core_valid_o,
    input  logic [DATA_W-1:0] core_quotient_i,
    input  logic [DATA_W-1:0] core_remainder_i,
    input  logic              core_valid_i,
    input  logic              core_idle_i
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SPECIAL = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_FIX     = 3'd4
    } state_t;

    localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

    // Two's-complement negate modulo 2^DATA_W when neg is set.
    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x, input logic neg);
        logic signed [DATA_W-1:0] xs;
        xs = $signed(x);
        return neg ? $unsigned(-xs) : x;
    endfunction

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic                sign_a_q, sign_a_d;
    logic                sign_b_q, sign_b_d;
    logic [DATA_W-1:0]   dividend_q, dividend_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                core_valid_q, core_valid_d;

    logic                accept;
    logic                is_signed;
    logic                div_zero;
    logic                ovfl;
    logic                in_sign_a;
    logic                in_sign_b;

    assign req_ready_o = (state_q == S_IDLE) & core_idle_i;
    assign accept      = req_valid_i & req_ready_o;
    assign is_signed   = ~op_i[0];
    assign in_sign_a   = is_signed & rs1_i[DATA_W-1];
    assign in_sign_b   = is_signed & rs2_i[DATA_W-1];
    assign div_zero    = (rs2_i == '0);
    assign ovfl        = is_signed & (rs1_i == MIN_NEG) & (rs2_i == ALL_ONES);

    // State register; frozen while the clock enable is low.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else if (clk_en_i) begin
            state_q <= state_d;
        end
    end

    // Next-state logic: special cases bypass the core entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = (div_zero | ovfl) ? S_SPECIAL : S_ISSUE;
            S_SPECIAL: state_d = S_IDLE;
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT:    if (core_valid_i) state_d = S_FIX;
            S_FIX:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values. Results are formed one edge early so the
    // registered result lines up with the SPECIAL/FIX cycle that strobes it.
    always_comb begin
        op_d           = op_q;
        sign_a_d       = sign_a_q;
        sign_b_d       = sign_b_q;
        dividend_d     = dividend_q;
        divisor_d      = divisor_q;
        result_d       = result_q;
        core_valid_d   = (state_d == S_ISSUE);
        result_valid_d = (state_d == S_SPECIAL) | (state_d == S_FIX);

        if ((state_q == S_IDLE) && accept) begin
            op_d       = op_i;
            sign_a_d   = in_sign_a;
            sign_b_d   = in_sign_b;
            dividend_d = cond_neg(rs1_i, in_sign_a);
            divisor_d  = cond_neg(rs2_i, in_sign_b);
            if (div_zero) begin
                result_d = op_i[1] ? rs1_i : ALL_ONES;
            end else if (ovfl) begin
                result_d = op_i[1] ? '0 : MIN_NEG;
            end
        end

        if ((state_q == S_WAIT) && core_valid_i) begin
            result_d = op_q[1] ? cond_neg(core_remainder_i, sign_a_q)
                               : cond_neg(core_quotient_i, sign_a_q ^ sign_b_q);
        end
    end

    // Datapath and strobe registers; all hold while the clock enable is low.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_q           <= '0;
            sign_a_q       <= 1'b0;
            sign_b_q       <= 1'b0;
            dividend_q     <= '0;
            divisor_q      <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            core_valid_q   <= 1'b0;
        end else if (clk_en_i) begin
            op_q           <= op_d;
            sign_a_q       <= sign_a_d;
            sign_b_q       <= sign_b_d;
            dividend_q     <= dividend_d;
            divisor_q      <= divisor_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            core_valid_q   <= core_valid_d;
        end
    end

    assign busy_o          = (state_q != S_IDLE);
    assign result_o        = result_q;
    assign result_valid_o  = result_valid_q;
    assign core_valid_o    = core_valid_q;
    assign core_dividend_o = dividend_q;
    assign core_divisor_o  = divisor_q;

endmodule
